// File: rtl/rdma_wr_data_framer_if.sv
// Request + AXI-stream payload channel bundle shared by both sides of the framer.
interface rdma_wr_data_framer_if #(
  parameter int DATA_BITS = 512,
  parameter int REQ_BITS  = 128
);
  logic                   req_valid;
  logic                   req_ready;
  logic [REQ_BITS-1:0]    req_data;
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;

  modport master (
    output req_valid, req_data, tvalid, tdata, tkeep, tlast,
    input  req_ready, tready
  );

  modport slave (
    input  req_valid, req_data, tvalid, tdata, tkeep, tlast,
    output req_ready, tready
  );
endinterface

// File: rtl/rdma_wr_data_framer.sv
// Pairs each write request with ceil(len/BEAT_BYTES) payload beats; request is issued one cycle
// after acceptance, payload passes through combinationally and is back-pressured outside DATA.
module rdma_wr_data_framer #(
  parameter int DATA_BITS = 512,
  parameter int REQ_BITS  = 128,
  parameter int LEN_BITS  = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  rdma_wr_data_framer_if.slave         s,
  rdma_wr_data_framer_if.master        m,
  output logic                         err_tlast,
  output logic [15:0]                  zero_len_cnt
);
  localparam int KEEP_BITS  = DATA_BITS / 8;
  localparam int BEAT_BYTES = KEEP_BITS;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t                  state;
  logic [REQ_BITS-1:0]     req_q;
  logic [LEN_BITS:0]       cnt;
  logic [BEAT_SHIFT-1:0]   rem_q;
  logic                    req_rdy_q;
  logic                    req_vld_q;

  logic [LEN_BITS-1:0]     len;
  logic [LEN_BITS:0]       beats;
  logic                    in_data;
  logic                    last;
  logic                    beat_hs;
  logic [KEEP_BITS-1:0]    last_keep;
  logic [KEEP_BITS-1:0]    keep;
  logic                    unused_keep;

  assign len   = s.req_data[64 +: LEN_BITS];
  // One extra bit keeps the round-up from wrapping at the maximum length.
  assign beats = ({1'b0, len} + (LEN_BITS+1)'(BEAT_BYTES-1)) >> BEAT_SHIFT;

  assign in_data   = (state == DATA);
  assign last      = (cnt == (LEN_BITS+1)'(1));
  assign beat_hs   = in_data && s.tvalid && m.tready;
  assign last_keep = (KEEP_BITS'(1) << rem_q) - KEEP_BITS'(1);

  // Incoming tkeep is ignored; the output keep is rebuilt from the request length.
  assign unused_keep = ^s.tkeep;

  always_comb begin
    keep = '0;
    if (in_data) keep = (last && rem_q != '0) ? last_keep : '1;
  end

  assign s.req_ready = req_rdy_q;
  assign m.req_valid = req_vld_q;
  assign m.req_data  = req_q;
  assign m.tvalid    = in_data && s.tvalid;
  assign s.tready    = in_data && m.tready;
  assign m.tdata     = in_data ? s.tdata : '0;
  assign m.tlast     = in_data && last;
  assign m.tkeep     = keep;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      req_q        <= '0;
      cnt          <= '0;
      rem_q        <= '0;
      req_rdy_q    <= 1'b0;
      req_vld_q    <= 1'b0;
      err_tlast    <= 1'b0;
      zero_len_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_rdy_q) begin
            req_rdy_q <= 1'b1;
          end else if (s.req_valid) begin
            if (len == '0) begin
              if (zero_len_cnt != 16'hFFFF) zero_len_cnt <= zero_len_cnt + 16'd1;
            end else begin
              req_q     <= s.req_data;
              cnt       <= beats;
              rem_q     <= len[BEAT_SHIFT-1:0];
              req_rdy_q <= 1'b0;
              req_vld_q <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (m.req_ready) begin
            req_vld_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            cnt <= cnt - (LEN_BITS+1)'(1);
            if (s.tlast != last) err_tlast <= 1'b1;
            if (last) begin
              state     <= IDLE;
              req_rdy_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rdma_wr_data_framer.sv
// Directed bench for rdma_wr_data_framer: request issue, beat framing, tkeep/tlast regeneration,
// zero-length drop, tlast error flag, randomized back-pressure and mid-packet reset.
module tb_rdma_wr_data_framer;
  localparam int CW = 576;
  typedef logic [CW-1:0] cv_t;

  logic aclk = 1'b0;
  logic areset;
  logic err_tlast;
  logic [15:0] zero_len_cnt;

  int checks = 0;
  int errors = 0;
  bit rnd = 1'b0;

  rdma_wr_data_framer_if #(.DATA_BITS(512), .REQ_BITS(128)) s_if ();
  rdma_wr_data_framer_if #(.DATA_BITS(512), .REQ_BITS(128)) m_if ();

  rdma_wr_data_framer #(.DATA_BITS(512), .REQ_BITS(128), .LEN_BITS(32)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s            (s_if.slave),
    .m            (m_if.master),
    .err_tlast    (err_tlast),
    .zero_len_cnt (zero_len_cnt)
  );

  always #5 aclk = ~aclk;

  logic [511:0] obs_dat[$];
  logic [63:0]  obs_keep[$];
  logic         obs_last[$];
  logic [127:0] obs_req[$];

  logic         prev_vld = 1'b0;
  logic         prev_rdy = 1'b0;
  logic [127:0] prev_dat = '0;

  task automatic chk(input string tag, input cv_t obs, input cv_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s", tag);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [511:0] pat(input int p, input int i);
    return {16{p[15:0], i[15:0]}};
  endfunction

  function automatic logic [127:0] mkreq(input int p, input logic [31:0] len);
    logic [31:0] hi;
    logic [63:0] va;
    hi = 32'hA5A5_0000 | 32'(p);
    va = 64'h0000_1000_0000_0000 + 64'(p) * 64'd4096;
    return {hi, len, va};
  endfunction

  // Handshakes complete on the following posedge, so record them half a cycle early.
  always @(negedge aclk) begin
    if (!areset) begin
      if (prev_vld && !prev_rdy)
        chk("req_stable", cv_t'({m_if.req_valid, m_if.req_data}), cv_t'({1'b1, prev_dat}));
      if (m_if.req_valid && m_if.req_ready) obs_req.push_back(m_if.req_data);
      if (m_if.tvalid && m_if.tready) begin
        obs_dat.push_back(m_if.tdata);
        obs_keep.push_back(m_if.tkeep);
        obs_last.push_back(m_if.tlast);
      end
    end
    prev_vld = m_if.req_valid;
    prev_rdy = m_if.req_ready;
    prev_dat = m_if.req_data;
  end

  task automatic send_req(input logic [127:0] r);
    int t;
    t = 0;
    s_if.req_valid = 1'b1;
    s_if.req_data  = r;
    @(negedge aclk);
    while (!s_if.req_ready) begin
      t++;
      if (t > 1000) timeout("s_req_ready");
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_if.req_valid = 1'b0;
  endtask

  task automatic send_beat(input int p, input int i, input logic tl);
    int t;
    t = 0;
    if (rnd && $urandom_range(0, 1) == 1) begin
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = pat(p, i);
    s_if.tkeep  = '1;
    s_if.tlast  = tl;
    @(negedge aclk);
    while (!s_if.tready) begin
      t++;
      if (t > 1000) timeout("s_axis_tready");
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic check_pkt(input int p, input logic [31:0] len, input int nb,
                           input logic [63:0] keep_last);
    int n;
    chk("req_cnt", cv_t'(obs_req.size()), cv_t'(1));
    if (obs_req.size() > 0) chk("req_dat", cv_t'(obs_req.pop_front()), cv_t'(mkreq(p, len)));
    n = obs_dat.size();
    chk("beat_cnt", cv_t'(n), cv_t'(nb));
    for (int i = 0; i < n; i++) begin
      chk("tdata", cv_t'(obs_dat[i]), cv_t'(pat(p, i)));
      chk("tlast", cv_t'(obs_last[i]), cv_t'(i == nb - 1));
      chk("tkeep", cv_t'(obs_keep[i]), cv_t'((i == nb - 1) ? keep_last : 64'hFFFF_FFFF_FFFF_FFFF));
    end
    obs_req.delete();
    obs_dat.delete();
    obs_keep.delete();
    obs_last.delete();
  endtask

  task automatic run_pkt(input int p, input logic [31:0] len, input int nb, input int tl_pos,
                         input logic [63:0] keep_last);
    send_req(mkreq(p, len));
    for (int i = 0; i < nb; i++) send_beat(p, i, i == tl_pos);
    check_pkt(p, len, nb, keep_last);
  endtask

  initial begin
    logic [63:0] kl;
    logic [31:0] len;
    int nb;

    areset         = 1'b1;
    s_if.req_valid = 1'b0;
    s_if.req_data  = '0;
    s_if.tvalid    = 1'b0;
    s_if.tdata     = '0;
    s_if.tkeep     = '0;
    s_if.tlast     = 1'b0;
    m_if.req_ready = 1'b1;
    m_if.tready    = 1'b1;

    fork
      forever begin
        @(posedge aclk);
        #1;
        m_if.tready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        m_if.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    #1;
    chk("rst_s_req_ready", cv_t'(s_if.req_ready), cv_t'(0));
    chk("rst_m_req_valid", cv_t'(m_if.req_valid), cv_t'(0));
    chk("rst_s_tready", cv_t'(s_if.tready), cv_t'(0));
    chk("rst_m_tvalid", cv_t'(m_if.tvalid), cv_t'(0));
    chk("rst_err_tlast", cv_t'(err_tlast), cv_t'(0));
    chk("rst_zero_len", cv_t'(zero_len_cnt), cv_t'(0));

    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("idle_s_req_ready", cv_t'(s_if.req_ready), cv_t'(1));

    // len=128: two full beats
    run_pkt(1, 32'd128, 2, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("err_clean_128", cv_t'(err_tlast), cv_t'(0));

    // len=100: rem 36
    run_pkt(2, 32'd100, 2, 1, 64'h0000_000F_FFFF_FFFF);

    // len=65: one byte on the last beat
    run_pkt(3, 32'd65, 2, 1, 64'h0000_0000_0000_0001);

    // zero-length request is dropped and counted
    send_req(mkreq(4, 32'd0));
    repeat (3) @(posedge aclk);
    #1;
    chk("zero_len_no_req", cv_t'(obs_req.size()), cv_t'(0));
    chk("zero_len_cnt", cv_t'(zero_len_cnt), cv_t'(1));
    run_pkt(5, 32'd64, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("err_clean_64", cv_t'(err_tlast), cv_t'(0));

    // early input tlast on beat 2 of 3
    run_pkt(6, 32'd192, 3, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("err_early_tlast", cv_t'(err_tlast), cv_t'(1));
    run_pkt(7, 32'd64, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("err_sticky", cv_t'(err_tlast), cv_t'(1));

    // randomized back-pressure
    rnd = 1'b1;
    for (int k = 0; k < 200; k++) begin
      len = 32'($urandom_range(1, 4096));
      nb  = int'((len + 32'd63) / 32'd64);
      kl  = '0;
      if (len % 32'd64 == 32'd0) kl = '1;
      else for (int b = 0; b < int'(len % 32'd64); b++) kl[b] = 1'b1;
      run_pkt(100 + k, len, nb, nb - 1, kl);
    end
    rnd = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("err_sticky_rand", cv_t'(err_tlast), cv_t'(1));

    // reset during beat 3 of 8
    send_req(mkreq(8, 32'd512));
    send_beat(8, 0, 1'b0);
    send_beat(8, 1, 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = pat(8, 2);
    #1;
    chk("pre_rst_tvalid", cv_t'(m_if.tvalid), cv_t'(1));
    areset = 1'b1;
    #1;
    chk("mid_rst_m_tvalid", cv_t'(m_if.tvalid), cv_t'(0));
    chk("mid_rst_s_tready", cv_t'(s_if.tready), cv_t'(0));
    chk("mid_rst_tlast_keep", cv_t'({m_if.tlast, m_if.tkeep}), cv_t'(0));
    chk("mid_rst_s_req_ready", cv_t'(s_if.req_ready), cv_t'(0));
    chk("mid_rst_err", cv_t'(err_tlast), cv_t'(0));
    chk("mid_rst_zero_len", cv_t'(zero_len_cnt), cv_t'(0));
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    obs_req.delete();
    obs_dat.delete();
    obs_keep.delete();
    obs_last.delete();
    run_pkt(9, 32'd64, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_err", cv_t'(err_tlast), cv_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
